div_arbiter: RTL and testbench
==============================

# div_arbiter

Shares one iterative 32-bit divider core between two independent requesters, e.g. the CPU-side divider peripheral and a second bus master. Arbitrates round-robin, loads operands, issues a one-cycle start pulse, waits for completion with a watchdog, and returns the quotient to the granted requester. Sits between the requester-side peripherals and the single divider core instance.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent waiting for divider ready before aborting with error.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  request; held high with operands stable until the matching ack
- dv0 / dv1  in  32  dividend
- dr0 / dr1  in  32  divisor
- ack0 / ack1  out  1  one-cycle completion pulse
- res0 / res1  out  32  quotient; valid when ack is high, holds its value otherwise
- err0 / err1  out  1  valid with ack: 1 = divide-by-zero or timeout
- div_dv  out  32  divider dividend, registered
- div_dr  out  32  divider divisor, registered
- div_init  out  1  divider start pulse, exactly one cycle
- div_ready  in  1  divider ready/done level
- div_result  in  32  divider quotient
- busy  out  1  high in every state except IDLE
- grant  out  2  one-hot owner of the current operation; 0 in IDLE

## Operation
- FSM states: IDLE, LAUNCH, SETTLE, WAIT, RESP.
- IDLE: if any req is high, pick the winner via round-robin. A single requester always wins. With both high, the winner is the requester not served last. Then set grant and load div_dv/div_dr from the winner's operands.
  - If the winner's divisor is 0: go to RESP with result 32'hFFFF_FFFF and err=1. The divider is not started.
  - Otherwise go to LAUNCH.
- LAUNCH: div_init=1 for this cycle only, then go to SETTLE.
- SETTLE: one cycle. div_ready is ignored because it may still be high from the previous operation. Then go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - div_ready=1: capture div_result, err=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES: result 0, err=1, go to RESP.
- RESP: ack, res and err are driven for the granted requester only, for one cycle. The last-served pointer is updated to that requester. Then go to IDLE, where grant clears.
- div_dv/div_dr change only on a grant and stay stable until the next grant.
- A req still high at the edge that ends the RESP cycle is treated as a new request.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and clears on entry to WAIT.

## Timing
- Reset values:
  - State IDLE; ack*, err*, div_init, busy and grant are 0.
  - res*, div_dv and div_dr are 0.
  - Last-served pointer = requester 1, so requester 0 wins the first tie.
- Cycle numbering: req sampled in IDLE at cycle 0; LAUNCH is cycle 1; SETTLE is cycle 2; WAIT starts at cycle 3.
  - If div_ready is seen in WAIT at cycle k (k ≥ 3), ack is high at cycle k+1.
  - Minimum latency is 4 cycles from request to ack.
- Divide-by-zero: ack at cycle 1.
- Timeout: ack at cycle 3+TIMEOUT_CYCLES.
- Requests arriving while busy wait; no queueing beyond the held req level.
- Deasserting req mid-operation does not abort. The ack is still issued.
- rst at any cycle, including LAUNCH or WAIT, returns to IDLE on the next edge with all outputs at reset values. The divider shares rst.

## Structure
- Shared package div_arbiter_pkg:
  - state enum (IDLE, LAUNCH, SETTLE, WAIT, RESP)
  - DIV_ZERO_RESULT = 32'hFFFF_FFFF
  - NUM_REQ = 2
- Sub-module rr_arbiter2: combinational two-way round-robin pick from {req1, req0} and the last-served bit, producing a one-hot grant. The pointer register stays in div_arbiter.

## Test plan
- req0 alone, dv0=100, dr0=7, divider model ready 10 cycles after init → div_init pulses once at cycle 1; ack0 at cycle 13 with res0=14, err0=0; ack1 never asserts.
- req0 and req1 together (100/7 and 81/9), both held until their own ack → requester 0 is served first (res0=14), then requester 1 (res1=9); grant sequence 01, 0, 10.
- req1 with dr1=0 → no div_init; ack1 at cycle 1 with res1=FFFF_FFFF, err1=1.
- Divider model never raises ready, TIMEOUT_CYCLES=64 → ack0 at cycle 67 with res0=0, err0=1; next request is served normally.
- div_ready held high from before the start → it is ignored in SETTLE; result captured at cycle 3, ack at cycle 4.
- rst asserted in WAIT → next cycle state is IDLE, busy=0, grant=0, and no ack is issued; a fresh req0 then completes normally.

Source files
------------

// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
package div_arbiter_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 32;

    localparam logic [DATA_W-1:0] DIV_ZERO_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/div_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter2
    import div_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between two requesters with round-robin arbitration,
// a single-cycle start pulse, a settle cycle and a ready watchdog.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] dv0,
    input  logic [DATA_W-1:0] dv1,
    input  logic [DATA_W-1:0] dr0,
    input  logic [DATA_W-1:0] dr1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] res0,
    output logic [DATA_W-1:0] res1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] div_dv,
    output logic [DATA_W-1:0] div_dr,
    output logic              div_init,
    input  logic              div_ready,
    input  logic [DATA_W-1:0] div_result,
    output logic              busy,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_d;
    logic                last, last_d;
    logic [NUM_REQ-1:0]  pick, grant_d;
    logic [DATA_W-1:0]   win_dv, win_dr, dv_d, dr_d, res0_d, res1_d, rv;
    logic                ack0_d, ack1_d, err0_d, err1_d, init_d, busy_d, ev;
    logic                timed_out;

    rr_arbiter2 u_rr (
        .req  ({req1, req0}),
        .last (last),
        .gnt  (pick)
    );

    assign win_dv    = pick[1] ? dv1 : dv0;
    assign win_dr    = pick[1] ? dr1 : dr0;
    assign timed_out = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pick) state_nxt = (win_dr == '0) ? RESP : LAUNCH;
            LAUNCH:  state_nxt = SETTLE;
            SETTLE:  state_nxt = WAIT;
            WAIT:    if (div_ready || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for every registered output; ack/res/err are loaded on entry to RESP.
    always_comb begin
        grant_d = grant;
        dv_d    = div_dv;
        dr_d    = div_dr;
        cnt_d   = '0;
        last_d  = last;
        rv      = '0;
        ev      = 1'b1;
        case (state)
            IDLE: begin
                if (|pick) begin
                    grant_d = pick;
                    dv_d    = win_dv;
                    dr_d    = win_dr;
                    rv      = DIV_ZERO_RESULT;
                end
            end
            WAIT: begin
                cnt_d = cnt + CW'(1);
                if (div_ready) begin
                    rv = div_result;
                    ev = 1'b0;
                end
            end
            RESP: begin
                last_d  = grant[1];
                grant_d = '0;
            end
            default: ;
        endcase
        ack0_d = (state_nxt == RESP) && grant_d[0];
        ack1_d = (state_nxt == RESP) && grant_d[1];
        res0_d = ack0_d ? rv : res0;
        res1_d = ack1_d ? rv : res1;
        err0_d = ack0_d & ev;
        err1_d = ack1_d & ev;
        init_d = (state_nxt == LAUNCH);
        busy_d = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= '0;
            div_dv   <= '0;
            div_dr   <= '0;
            cnt      <= '0;
            last     <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            res0     <= '0;
            res1     <= '0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            div_init <= 1'b0;
            busy     <= 1'b0;
        end else begin
            grant    <= grant_d;
            div_dv   <= dv_d;
            div_dr   <= dr_d;
            cnt      <= cnt_d;
            last     <= last_d;
            ack0     <= ack0_d;
            ack1     <= ack1_d;
            res0     <= res0_d;
            res1     <= res1_d;
            err0     <= err0_d;
            err1     <= err1_d;
            div_init <= init_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural iterative-divider model.
module tb_div_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] dv0 = '0, dv1 = '0, dr0 = '0, dr1 = '0;
    logic        ack0, ack1, err0, err1, div_init, busy;
    logic [31:0] res0, res1, div_dv, div_dr;
    logic        div_ready;
    logic [31:0] div_result;
    logic [1:0]  grant;

    int vectors = 0;
    int miscompares = 0;

    // Divider model: ready rises lat cycles after the cycle following init, stays high until next init.
    int          lat = 10;
    logic        hang = 1'b0;
    logic        force_rdy = 1'b0;
    int          mcnt;
    logic        done;
    logic [31:0] q;

    int n_init = 0, n_ack0 = 0, n_ack1 = 0;

    always #5 clk = ~clk;

    div_arbiter #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .dv0(dv0), .dv1(dv1), .dr0(dr0), .dr1(dr1),
        .ack0(ack0), .ack1(ack1), .res0(res0), .res1(res1),
        .err0(err0), .err1(err1),
        .div_dv(div_dv), .div_dr(div_dr), .div_init(div_init),
        .div_ready(div_ready), .div_result(div_result),
        .busy(busy), .grant(grant)
    );

    always @(posedge clk) begin
        if (rst) begin
            mcnt <= 0;
            done <= 1'b0;
            q    <= '0;
        end else if (div_init) begin
            mcnt <= lat;
            done <= 1'b0;
            q    <= (div_dr != 0) ? div_dv / div_dr : 32'hFFFF_FFFF;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !hang) done <= 1'b1;
        end
    end

    assign div_ready  = force_rdy | done;
    assign div_result = q;

    always @(negedge clk) begin
        if (div_init) n_init++;
        if (ack0)     n_ack0++;
        if (ack1)     n_ack1++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int which, input int start, output int cyc);
        cyc = start;
        do begin
            step();
            cyc++;
        end while (!((which == 0) ? ack0 : ack1) && cyc < start + 300);
    endtask

    int cyc, i0, a0, a1;

    initial begin
        // Reset values
        apply_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ack0", 32'(ack0), 0);
        chk("rst_ack1", 32'(ack1), 0);
        chk("rst_err0", 32'(err0), 0);
        chk("rst_err1", 32'(err1), 0);
        chk("rst_init", 32'(div_init), 0);
        chk("rst_res0", res0, 0);
        chk("rst_res1", res1, 0);
        chk("rst_div_dv", div_dv, 0);
        chk("rst_div_dr", div_dr, 0);

        // req0 alone, 100/7, ready 10 cycles after init
        i0 = n_init; a1 = n_ack1;
        lat = 10; dv0 = 100; dr0 = 7; req0 = 1'b1;
        step();
        chk("t1_init_c1", 32'(div_init), 1);
        chk("t1_grant_c1", 32'(grant), 32'h1);
        chk("t1_busy_c1", 32'(busy), 1);
        chk("t1_div_dv", div_dv, 100);
        chk("t1_div_dr", div_dr, 7);
        step();
        chk("t1_init_c2", 32'(div_init), 0);
        wait_ack(0, 2, cyc);
        chk("t1_ack_cycle", 32'(cyc), 13);
        chk("t1_res0", res0, 14);
        chk("t1_err0", 32'(err0), 0);
        req0 = 1'b0;
        step();
        chk("t1_init_count", 32'(n_init - i0), 1);
        chk("t1_no_ack1", 32'(n_ack1 - a1), 0);
        chk("t1_grant_idle", 32'(grant), 0);
        chk("t1_busy_idle", 32'(busy), 0);
        chk("t1_ack0_pulse", 32'(ack0), 0);
        chk("t1_res0_hold", res0, 14);

        // Tie after reset: requester 0 first, then requester 1
        apply_reset();
        dv0 = 100; dr0 = 7; dv1 = 81; dr1 = 9; req0 = 1'b1; req1 = 1'b1;
        step();
        chk("t2_grant_first", 32'(grant), 32'h1);
        wait_ack(0, 1, cyc);
        chk("t2_ack0_cycle", 32'(cyc), 13);
        chk("t2_res0", res0, 14);
        chk("t2_ack1_quiet", 32'(ack1), 0);
        req0 = 1'b0;
        step();
        chk("t2_grant_idle", 32'(grant), 0);
        step();
        chk("t2_grant_second", 32'(grant), 32'h2);
        chk("t2_div_dv2", div_dv, 81);
        wait_ack(1, 1, cyc);
        chk("t2_ack1_cycle", 32'(cyc), 13);
        chk("t2_res1", res1, 9);
        chk("t2_err1", 32'(err1), 0);
        req1 = 1'b0;
        step();

        // Divide by zero on requester 1
        apply_reset();
        i0 = n_init;
        dv1 = 5; dr1 = 0; req1 = 1'b1;
        step();
        chk("t3_ack1", 32'(ack1), 1);
        chk("t3_res1", res1, 32'hFFFF_FFFF);
        chk("t3_err1", 32'(err1), 1);
        chk("t3_ack0_quiet", 32'(ack0), 0);
        chk("t3_grant", 32'(grant), 32'h2);
        req1 = 1'b0;
        step();
        chk("t3_no_init", 32'(n_init - i0), 0);
        chk("t3_ack1_pulse", 32'(ack1), 0);
        chk("t3_busy_idle", 32'(busy), 0);

        // Timeout, then a normal operation
        apply_reset();
        hang = 1'b1; dv0 = 50; dr0 = 5; req0 = 1'b1;
        wait_ack(0, 0, cyc);
        chk("t4_timeout_cycle", 32'(cyc), 67);
        chk("t4_res0", res0, 0);
        chk("t4_err0", 32'(err0), 1);
        req0 = 1'b0; hang = 1'b0;
        step();
        dv0 = 81; dr0 = 9; req0 = 1'b1;
        wait_ack(0, 0, cyc);
        chk("t4_next_cycle", 32'(cyc), 13);
        chk("t4_next_res0", res0, 9);
        chk("t4_next_err0", 32'(err0), 0);
        req0 = 1'b0;
        step();

        // Ready already high before start: ignored in SETTLE
        apply_reset();
        force_rdy = 1'b1; dv1 = 1000; dr1 = 10; req1 = 1'b1;
        wait_ack(1, 0, cyc);
        chk("t5_ack_cycle", 32'(cyc), 4);
        chk("t5_res1", res1, 100);
        chk("t5_err1", 32'(err1), 0);
        req1 = 1'b0; force_rdy = 1'b0;
        step();

        // Reset while waiting on the divider
        apply_reset();
        lat = 10; dv0 = 77; dr0 = 7; req0 = 1'b1;
        repeat (4) step();
        chk("t6_busy_wait", 32'(busy), 1);
        rst = 1'b1; req0 = 1'b0; a0 = n_ack0;
        step();
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_grant", 32'(grant), 0);
        chk("t6_ack0", 32'(ack0), 0);
        chk("t6_div_dv", div_dv, 0);
        chk("t6_init", 32'(div_init), 0);
        repeat (15) step();
        chk("t6_no_ack", 32'(n_ack0 - a0), 0);
        req0 = 1'b1;
        wait_ack(0, 0, cyc);
        chk("t6_fresh_cycle", 32'(cyc), 13);
        chk("t6_fresh_res0", res0, 11);
        chk("t6_fresh_err0", 32'(err0), 0);
        req0 = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
